// File: rtl/vga_frame_reader_pkg.sv
// Raster/image geometry defaults and shared types for the frame-buffer reader.
package vga_frame_reader_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_IMG_W    = 320;
    localparam int DEF_IMG_H    = 240;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t DEF_BG_COLOR = 16'h0000;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/vga_frame_reader_delay_line.sv
// Fixed-depth shift register that keeps raster control bits aligned with RAM read data.
module vga_frame_reader_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_frame_reader.sv
// Turns raster position into 2x-upscaled frame-buffer reads and returns RGB565 pixels
// aligned with the delayed sync signals.
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int      IMG_W    = DEF_IMG_W,
    parameter int      IMG_H    = DEF_IMG_H,
    parameter int      H_ACTIVE = DEF_H_ACTIVE,
    parameter int      V_ACTIVE = DEF_V_ACTIVE,
    parameter int      RAM_LAT  = 1,
    parameter rgb565_t BG_COLOR = DEF_BG_COLOR
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        visible,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [16:0] ram_addr,
    output logic        ram_rd_en,
    input  logic [15:0] ram_rdata,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [16:0] ADDR_MAX  = 17'(IMG_W * IMG_H - 1);
    localparam logic [16:0] BASE_MAX  = 17'((IMG_H - 1) * IMG_W);
    localparam logic [16:0] LINE_STEP = 17'(IMG_W);
    localparam logic [9:0]  H_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_END     = 10'(V_ACTIVE);

    function automatic logic [16:0] sat_add(input logic [16:0] a, input logic [16:0] b,
                                            input logic [16:0] lim);
        logic [17:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) return lim;
        return sum[16:0];
    endfunction

    lock_state_t r_state;
    logic [16:0] r_addr;
    logic [16:0] r_line_base;
    logic        r_x_phase;
    logic [16:0] r_ram_addr;
    logic        r_ram_rd_en;
    rgb565_t     r_pixel_data;
    logic        r_pixel_valid;
    logic        r_hsync;
    logic        r_vsync;

    logic        w_frame_start;
    logic        w_lock_now;
    logic        w_read;
    logic        w_line_end;
    logic [16:0] w_cur_addr;
    logic [16:0] w_cur_base;
    logic        w_cur_phase;
    logic [16:0] w_next_base;
    logic [16:0] w_inc_addr;
    logic [2:0]  w_dly;

    // Frame start behaves as if the counters were already cleared, so pixel (0,0) reads address 0.
    assign w_frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign w_lock_now    = (r_state == ST_LOCKED) || w_frame_start;
    assign w_read        = visible && w_lock_now;
    assign w_line_end    = w_read && (h_cnt == H_LAST) && (v_cnt < V_END);
    assign w_cur_addr    = w_frame_start ? '0 : r_addr;
    assign w_cur_base    = w_frame_start ? '0 : r_line_base;
    assign w_cur_phase   = w_frame_start ? 1'b0 : r_x_phase;
    assign w_next_base   = v_cnt[0] ? sat_add(w_cur_base, LINE_STEP, BASE_MAX) : w_cur_base;
    assign w_inc_addr    = sat_add(w_cur_addr, 17'd1, ADDR_MAX);

    // Stage p0: lock FSM and address generation
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_state     <= ST_UNLOCKED;
            r_addr      <= '0;
            r_line_base <= '0;
            r_x_phase   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_rd_en <= 1'b0;
        end else begin
            if (w_frame_start) r_state <= ST_LOCKED;
            r_ram_rd_en <= w_read;
            if (w_read) begin
                r_ram_addr <= w_cur_addr;
                if (w_line_end) begin
                    // Odd raster lines advance to the next image line, even lines repeat it.
                    r_line_base <= w_next_base;
                    r_addr      <= w_next_base;
                    r_x_phase   <= 1'b0;
                end else begin
                    r_line_base <= w_cur_base;
                    r_x_phase   <= ~w_cur_phase;
                    r_addr      <= w_cur_phase ? w_inc_addr : w_cur_addr;
                end
            end else if (w_frame_start) begin
                r_addr      <= '0;
                r_line_base <= '0;
                r_x_phase   <= 1'b0;
            end
        end
    end

    vga_frame_reader_delay_line #(
        .DEPTH (RAM_LAT + 1),
        .WIDTH (3)
    ) u_ctrl_dly (
        .i_clk (clk_50mhz),
        .i_rst (rst),
        .i_d   ({w_read, hsync_in, vsync_in}),
        .o_q   (w_dly)
    );

    // Stage p1: RAM data capture aligned with the delayed control bits
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_pixel_data  <= BG_COLOR;
            r_pixel_valid <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
        end else begin
            r_pixel_data  <= w_dly[2] ? ram_rdata : BG_COLOR;
            r_pixel_valid <= w_dly[2];
            r_hsync       <= w_dly[1];
            r_vsync       <= w_dly[0];
        end
    end

    assign ram_addr    = r_ram_addr;
    assign ram_rd_en   = r_ram_rd_en;
    assign pixel_data  = r_pixel_data;
    assign pixel_valid = r_pixel_valid;
    assign hsync_out   = r_hsync;
    assign vsync_out   = r_vsync;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: position-based address model plus a pixel scoreboard queue.
module tb_vga_frame_reader;
    import vga_frame_reader_pkg::*;

    localparam int HT   = 656;
    localparam int HS0  = 644;
    localparam int HS1  = 652;
    localparam logic [15:0] BG1 = 16'h0000;
    localparam logic [15:0] BG3 = 16'h07E0;
    localparam int S_IW = 8;
    localparam int S_IH = 6;
    localparam int S_HA = 16;
    localparam int S_VA = 12;
    localparam int S_HT = 20;
    localparam int S_VT = 14;

    logic clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        visible, hsync_in, vsync_in;
    logic [16:0] addr1, addr3;
    logic        rd1, rd3;
    logic [15:0] rdata1, rdata3, pd1, pd3;
    logic        pv1, pv3, hso1, hso3, vso1, vso3;

    logic [9:0]  s_h, s_v;
    logic        s_vis, s_hs, s_vs;
    logic [16:0] s_addr;
    logic        s_rd;
    logic [15:0] s_rdata, s_pd;
    logic        s_pv, s_hso, s_vso;

    vga_frame_reader #(.RAM_LAT(1), .BG_COLOR(BG1)) dut1 (
        .clk_50mhz(clk_50mhz), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .ram_addr(addr1), .ram_rd_en(rd1),
        .ram_rdata(rdata1), .pixel_data(pd1), .pixel_valid(pv1), .hsync_out(hso1), .vsync_out(vso1));

    vga_frame_reader #(.RAM_LAT(3), .BG_COLOR(BG3)) dut3 (
        .clk_50mhz(clk_50mhz), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .ram_addr(addr3), .ram_rd_en(rd3),
        .ram_rdata(rdata3), .pixel_data(pd3), .pixel_valid(pv3), .hsync_out(hso3), .vsync_out(vso3));

    vga_frame_reader #(.IMG_W(S_IW), .IMG_H(S_IH), .H_ACTIVE(S_HA), .V_ACTIVE(S_VA),
                       .RAM_LAT(2), .BG_COLOR(16'h0000)) dut_s (
        .clk_50mhz(clk_50mhz), .rst(rst), .h_cnt(s_h), .v_cnt(s_v), .visible(s_vis),
        .hsync_in(s_hs), .vsync_in(s_vs), .ram_addr(s_addr), .ram_rd_en(s_rd),
        .ram_rdata(s_rdata), .pixel_data(s_pd), .pixel_valid(s_pv), .hsync_out(s_hso), .vsync_out(s_vso));

    // Frame-buffer models: contents equal the low 16 address bits, fixed read latency.
    logic [15:0] m1_q;
    logic [15:0] m3_q [3];
    logic [15:0] ms_q [2];
    always @(posedge clk_50mhz) begin
        m1_q     <= rd1 ? addr1[15:0] : 16'hDEAD;
        m3_q[0]  <= rd3 ? addr3[15:0] : 16'hDEAD;
        m3_q[1]  <= m3_q[0];
        m3_q[2]  <= m3_q[1];
        ms_q[0]  <= s_rd ? s_addr[15:0] : 16'hDEAD;
        ms_q[1]  <= ms_q[0];
    end
    assign rdata1  = m1_q;
    assign rdata3  = m3_q[2];
    assign s_rdata = ms_q[1];

    typedef struct packed {
        logic [15:0] a;
        logic        pv;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    int          n_pass = 0;
    int          n_total = 0;
    bit          lock_m;
    int          rd_cnt;
    logic [16:0] hold_addr;
    int          hist [S_IW*S_IH];
    int          s_reads;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model_addr(input int v, input int cnt, input int w, input int hg);
        int base;
        int a;
        base = (v / 2) * w;
        if (base > (hg - 1) * w) base = (hg - 1) * w;
        a = base + cnt / 2;
        if (a > w * hg - 1) a = w * hg - 1;
        return 17'(a);
    endfunction

    task automatic step(input int h, input int v, input logic vis, input logic hs, input logic vs);
        exp_t        e;
        logic        rd;
        logic [16:0] a;
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        visible  = vis;
        hsync_in = hs;
        vsync_in = vs;
        if (h == 0 && v == 0) lock_m = 1'b1;
        rd = vis && lock_m;
        a  = model_addr(v, rd_cnt, DEF_IMG_W, DEF_IMG_H);
        if (rd) begin
            hold_addr = a;
            rd_cnt++;
        end
        e.a  = hold_addr[15:0];
        e.pv = rd;
        e.hs = hs;
        e.vs = vs;
        q1.push_back(e);
        q3.push_back(e);
        @(posedge clk_50mhz);
        #1;
        chk("rd_en_lat1", rd1, rd);
        chk("addr_lat1", addr1, hold_addr);
        chk("rd_en_lat3", rd3, rd);
        chk("addr_lat3", addr3, hold_addr);
        if (q1.size() > 2) begin
            e = q1.pop_front();
            chk("pixel_lat1", pd1, e.pv ? e.a : BG1);
            chk("valid_lat1", pv1, e.pv);
            chk("hsync_lat1", hso1, e.hs);
            chk("vsync_lat1", vso1, e.vs);
        end
        if (q3.size() > 4) begin
            e = q3.pop_front();
            chk("pixel_lat3", pd3, e.pv ? e.a : BG3);
            chk("valid_lat3", pv3, e.pv);
            chk("hsync_lat3", hso3, e.hs);
            chk("vsync_lat3", vso3, e.vs);
        end
    endtask

    // full=0 drives only the last visible pixel plus a short sync, to advance lines cheaply.
    task automatic line(input int v, input bit full, input logic vs);
        rd_cnt = 0;
        if (full) begin
            for (int h = 0; h < HT; h++) step(h, v, (h < 640) && (v < 480), (h >= HS0) && (h < HS1), vs);
        end else begin
            step(639, v, v < 480, 1'b0, vs);
            step(HS0, v, 1'b0, 1'b1, vs);
            step(HS0 + 1, v, 1'b0, 1'b0, vs);
        end
    endtask

    task automatic blank(input int v, input int n, input logic vs);
        rd_cnt = 0;
        for (int i = 0; i < n; i++) step(640 + i, v, 1'b0, (i % 4) == 1, vs);
    endtask

    task automatic check_reset_values();
        chk("rst_addr1", addr1, 17'd0);
        chk("rst_rd1", rd1, 1'b0);
        chk("rst_pd1", pd1, BG1);
        chk("rst_pv1", pv1, 1'b0);
        chk("rst_sync1", {hso1, vso1}, 2'b00);
        chk("rst_addr3", addr3, 17'd0);
        chk("rst_rd3", rd3, 1'b0);
        chk("rst_pd3", pd3, BG3);
        chk("rst_pv3", pv3, 1'b0);
        chk("rst_sync3", {hso3, vso3}, 2'b00);
    endtask

    initial begin
        logic        srd;
        logic [16:0] sa;
        logic [16:0] shold;
        int          scnt;

        rst = 1'b1;
        h_cnt = 10'd200; v_cnt = 10'd50; visible = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        s_h = 10'd5; s_v = 10'd13; s_vis = 1'b0; s_hs = 1'b0; s_vs = 1'b1;
        lock_m = 1'b0; rd_cnt = 0; hold_addr = '0;
        for (int i = 0; i < S_IW*S_IH; i++) hist[i] = 0;
        repeat (3) @(posedge clk_50mhz);
        #1;
        check_reset_values();
        rst = 1'b0;

        // Lock on a frame, then reset asynchronously in the middle of line 2.
        line(0, 1'b1, 1'b0);
        line(1, 1'b0, 1'b0);
        rd_cnt = 0;
        for (int h = 0; h < 10; h++) step(h, 2, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_values();
        lock_m = 1'b0; hold_addr = '0; q1.delete(); q3.delete();
        repeat (2) @(posedge clk_50mhz);
        #1;
        rst = 1'b0;

        // Released mid-frame at v=100: no reads until the next frame start.
        line(100, 1'b1, 1'b0);
        line(101, 1'b0, 1'b0);
        blank(480, 8, 1'b1);
        chk("unlocked_no_read", rd1, 1'b0);

        // Full frame with line fast-forward between lines 3 and 477.
        line(0, 1'b1, 1'b0);
        line(1, 1'b1, 1'b0);
        line(2, 1'b1, 1'b0);
        for (int v = 3; v < 478; v++) line(v, 1'b0, 1'b0);
        line(478, 1'b1, 1'b0);
        line(479, 1'b1, 1'b0);
        chk("last_addr_lat1", addr1, 17'd76799);
        chk("last_addr_lat3", addr3, 17'd76799);
        blank(480, 8, 1'b1);
        blank(481, 8, 1'b1);
        chk("blank_hold_addr", addr1, 17'd76799);
        chk("blank_valid", pv1, 1'b0);
        chk("blank_pixel", pd3, BG3);
        line(0, 1'b1, 1'b0);
        chk("restart_line0_end", addr1, 17'd319);
        line(1, 1'b0, 1'b0);
        blank(1, 6, 1'b0);

        // Reduced-geometry instance: two complete frames, every address read 4x per frame.
        shold = '0;
        s_reads = 0;
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < S_VT; v++) begin
                scnt = 0;
                for (int h = 0; h < S_HT; h++) begin
                    s_h   = 10'(h);
                    s_v   = 10'(v);
                    s_vis = (h < S_HA) && (v < S_VA);
                    s_hs  = (h == S_HA + 1);
                    s_vs  = (v >= S_VA);
                    srd   = s_vis;
                    sa    = model_addr(v, scnt, S_IW, S_IH);
                    if (srd) begin
                        shold = sa;
                        scnt++;
                    end
                    @(posedge clk_50mhz);
                    #1;
                    chk("small_rd_en", s_rd, srd);
                    chk("small_addr", s_addr, shold);
                    if (s_rd) begin
                        s_reads++;
                        if (s_addr < 17'(S_IW*S_IH)) hist[s_addr]++;
                    end
                end
            end
        end
        repeat (4) @(posedge clk_50mhz);
        #1;
        chk("small_total_reads", s_reads, 2 * S_IW * S_IH * 4);
        for (int i = 0; i < S_IW*S_IH; i++) chk("small_reads_per_addr", hist[i], 8);
        chk("small_idle_valid", s_pv, 1'b0);
        chk("small_idle_pixel", s_pd, 16'h0000);
        chk("small_idle_hsync", s_hso, 1'b0);
        chk("small_idle_vsync", s_vso, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
